instr_stream_encoder: RTL and testbench

Sequential MIPS instruction encoder and instruction-memory loader: the producing end of the opcode/control path. It accepts per-instruction class and field values over a valid/ready handshake, packs them into 32-bit MIPS words using the same opcode map the CPU's control decoder consumes (R, beq, addi, slti, lw, sw, j, jal), and writes them sequentially into instruction memory. It sits between the testbench/boot source and the CPU's instruction memory write port.

---
 rtl/mips_pkg.sv | 66 ++++++
 rtl/instr_field_pack.sv | 25 ++
 rtl/instr_stream_encoder.sv | 130 +++++++++++++
 tb/tb_instr_stream_encoder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encoding definitions: opcode map, instruction classes, encoder FSM
// states and the per-instruction field payload.
package mips_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned OP_W   = 6;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned FUNC_W = 6;
   localparam int unsigned IMM_W  = 16;
   localparam int unsigned TGT_W  = 26;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
   localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

   typedef enum logic [2:0] {
      CLS_R    = 3'd0,
      CLS_BEQ  = 3'd1,
      CLS_ADDI = 3'd2,
      CLS_SLTI = 3'd3,
      CLS_LW   = 3'd4,
      CLS_SW   = 3'd5,
      CLS_J    = 3'd6,
      CLS_JAL  = 3'd7
   } instr_class_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } enc_state_e;

   typedef struct packed {
      instr_class_e        cls;
      logic [REG_W-1:0]    rs;
      logic [REG_W-1:0]    rt;
      logic [REG_W-1:0]    rd;
      logic [REG_W-1:0]    shamt;
      logic [FUNC_W-1:0]   funct;
      logic [IMM_W-1:0]    imm;
      logic [TGT_W-1:0]    target;
   } instr_fields_t;

   // Opcode for each instruction class; shared with the control decoder.
   function automatic logic [OP_W-1:0] class_opcode(input instr_class_e cls);
      logic [OP_W-1:0] op;
      case (cls)
         CLS_R:    op = OP_RTYPE;
         CLS_BEQ:  op = OP_BEQ;
         CLS_ADDI: op = OP_ADDI;
         CLS_SLTI: op = OP_SLTI;
         CLS_LW:   op = OP_LW;
         CLS_SW:   op = OP_SW;
         CLS_J:    op = OP_J;
         CLS_JAL:  op = OP_JAL;
         default:  op = OP_RTYPE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: instruction class plus field values into one 32-bit
// MIPS word (R, I or J format as selected by the class).
module instr_field_pack
   import mips_pkg::*;
(
   input  instr_fields_t       fields,
   output logic [WORD_W-1:0]   word_c
);

   logic [OP_W-1:0] op;

   always_comb begin
      op     = class_opcode(fields.cls);
      word_c = '0;
      case (fields.cls)
         CLS_R:
            word_c = {OP_RTYPE, fields.rs, fields.rt, fields.rd, fields.shamt, fields.funct};
         CLS_J, CLS_JAL:
            word_c = {op, fields.target};
         default:
            word_c = {op, fields.rs, fields.rt, fields.imm};
      endcase
   end

endmodule

// File: rtl/instr_stream_encoder.sv
// Sequential MIPS instruction encoder / instruction-memory loader.
// Optional INSTR_ENC_CHECKSUM_EN adds checksum_o, the XOR of all words written this session.
module instr_stream_encoder
   import mips_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH     = 32,
   localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
)(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [2:0]          in_class_i,
   input  logic                in_last_i,
   input  logic [REG_W-1:0]    rs_i,
   input  logic [REG_W-1:0]    rt_i,
   input  logic [REG_W-1:0]    rd_i,
   input  logic [REG_W-1:0]    shamt_i,
   input  logic [FUNC_W-1:0]   funct_i,
   input  logic [IMM_W-1:0]    imm_i,
   input  logic [TGT_W-1:0]    target_i,
   output logic                mem_we_o,
   output logic [WORD_W-1:0]   mem_addr_o,
   output logic [WORD_W-1:0]   mem_wdata_o,
   output logic [CNT_W-1:0]    count_o,
`ifdef INSTR_ENC_CHECKSUM_EN
   output logic [WORD_W-1:0]   checksum_o,
`endif
   output logic                done_o
);

   enc_state_e          state_q;
   enc_state_e          state_d;
   instr_fields_t       fields;
   logic [WORD_W-1:0]   word_c;
   logic [WORD_W-1:0]   addr_ptr_q;
   logic [CNT_W-1:0]    count_next_c;
   logic                accept_c;
   logic                last_word_c;
   logic                enter_load_c;

   assign fields = '{
      cls:    instr_class_e'(in_class_i),
      rs:     rs_i,
      rt:     rt_i,
      rd:     rd_i,
      shamt:  shamt_i,
      funct:  funct_i,
      imm:    imm_i,
      target: target_i
   };

   instr_field_pack u_pack (
      .fields (fields),
      .word_c (word_c)
   );

   // Ready is a pure state decode so it can never coincide with start_i handling.
   assign in_ready_o   = (state_q == ST_LOAD);
   assign accept_c     = in_valid_i & in_ready_o;
   assign count_next_c = count_o + CNT_W'(1);
   assign last_word_c  = in_last_i | (count_next_c == CNT_W'(DEPTH));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      enter_load_c = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d      = ST_LOAD;
               enter_load_c = 1'b1;
            end
         end
         ST_LOAD: begin
            if (accept_c && last_word_c) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Write port, session pointer and word count; the final write lands alongside done_o.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mem_we_o    <= 1'b0;
         mem_addr_o  <= BASE_ADDR;
         mem_wdata_o <= '0;
         addr_ptr_q  <= BASE_ADDR;
         count_o     <= '0;
         done_o      <= 1'b0;
      end else begin
         mem_we_o <= accept_c;
         done_o   <= (state_d == ST_DONE);
         if (enter_load_c) begin
            addr_ptr_q <= BASE_ADDR;
            count_o    <= '0;
         end else if (accept_c) begin
            mem_addr_o  <= addr_ptr_q;
            mem_wdata_o <= word_c;
            addr_ptr_q  <= addr_ptr_q + 32'd4;
            count_o     <= count_next_c;
         end
      end
   end

`ifdef INSTR_ENC_CHECKSUM_EN
   // Running XOR tracks mem_wdata_o, so it updates on the same edge as the write.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         checksum_o <= '0;
      end else if (enter_load_c) begin
         checksum_o <= '0;
      end else if (accept_c) begin
         checksum_o <= checksum_o ^ word_c;
      end
   end
`endif

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Randomized self-checking bench: two encoder instances (deep at address 0, shallow
// straddling the 32-bit address wrap) checked every cycle against a transaction model.
module tb_instr_stream_encoder;

   logic        clk;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [2:0]  in_class;
   logic        in_last;
   logic [4:0]  rs, rt, rd, shamt;
   logic [5:0]  funct;
   logic [15:0] imm;
   logic [25:0] target;

   logic        ready_a, we_a, done_a;
   logic [31:0] addr_a, data_a;
   logic [5:0]  count_a;
   logic        ready_b, we_b, done_b;
   logic [31:0] addr_b, data_b;
   logic [2:0]  count_b;
`ifdef INSTR_ENC_CHECKSUM_EN
   logic [31:0] cks_a, cks_b;
`endif

   localparam logic [31:0] BASE_B = 32'hFFFF_FFF8;

   instr_stream_encoder #(.BASE_ADDR(32'h0000_0000), .DEPTH(32)) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid),
      .in_ready_o(ready_a), .in_class_i(in_class), .in_last_i(in_last),
      .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct),
      .imm_i(imm), .target_i(target), .mem_we_o(we_a), .mem_addr_o(addr_a),
      .mem_wdata_o(data_a), .count_o(count_a),
`ifdef INSTR_ENC_CHECKSUM_EN
      .checksum_o(cks_a),
`endif
      .done_o(done_a)
   );

   instr_stream_encoder #(.BASE_ADDR(BASE_B), .DEPTH(4)) dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start), .in_valid_i(in_valid),
      .in_ready_o(ready_b), .in_class_i(in_class), .in_last_i(in_last),
      .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt), .funct_i(funct),
      .imm_i(imm), .target_i(target), .mem_we_o(we_b), .mem_addr_o(addr_b),
      .mem_wdata_o(data_b), .count_o(count_b),
`ifdef INSTR_ENC_CHECKSUM_EN
      .checksum_o(cks_b),
`endif
      .done_o(done_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;
   int wr_a     = 0;
   int wr_b     = 0;

   // Session model per instance: loading flag, words accepted, expected write.
   int          depth_m [2] = '{32, 4};
   logic [31:0] base_m  [2] = '{32'h0000_0000, BASE_B};
   bit          m_load  [2];
   bit          m_done  [2];
   int          m_n     [2];
   bit          m_we    [2];
   logic [31:0] m_addr  [2];
   logic [31:0] m_data  [2];
   logic [31:0] m_csum  [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference word built arithmetically from the MIPS field positions.
   function automatic logic [31:0] ref_encode(input logic [2:0] cls, input logic [4:0] f_rs,
                                              input logic [4:0] f_rt, input logic [4:0] f_rd,
                                              input logic [4:0] f_sh, input logic [5:0] f_fn,
                                              input logic [15:0] f_imm, input logic [25:0] f_tgt);
      int          op_tab [8];
      logic [31:0] op32;
      op_tab = '{0, 4, 8, 10, 35, 43, 2, 3};
      op32   = 32'(op_tab[cls]);
      if (cls == 3'd0)
         return 32'(f_rs) * 32'h0020_0000 + 32'(f_rt) * 32'h0001_0000 +
                32'(f_rd) * 32'h0000_0800 + 32'(f_sh) * 32'h0000_0040 + 32'(f_fn);
      else if (cls >= 3'd6)
         return op32 * 32'h0400_0000 + 32'(f_tgt);
      else
         return op32 * 32'h0400_0000 + 32'(f_rs) * 32'h0020_0000 +
                32'(f_rt) * 32'h0001_0000 + 32'(f_imm);
   endfunction

   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         m_we[k] = 1'b0;
         if (rst) begin
            m_load[k] = 1'b0; m_done[k] = 1'b0; m_n[k] = 0; m_csum[k] = '0;
            m_addr[k] = base_m[k]; m_data[k] = '0;
         end else if (m_load[k] && in_valid) begin
            m_we[k]   = 1'b1;
            m_addr[k] = base_m[k] + 32'(4 * m_n[k]);
            m_data[k] = ref_encode(in_class, rs, rt, rd, shamt, funct, imm, target);
            m_csum[k] = m_csum[k] ^ m_data[k];
            m_n[k]++;
            if (in_last || m_n[k] == depth_m[k]) begin
               m_load[k] = 1'b0;
               m_done[k] = 1'b1;
            end
         end else if (start && !m_load[k]) begin
            m_load[k] = 1'b1; m_done[k] = 1'b0; m_n[k] = 0; m_csum[k] = '0;
         end
      end
   endtask

   task automatic check_all();
      chk("ready_a", 32'(ready_a), 32'(m_load[0]));
      chk("done_a",  32'(done_a),  32'(m_done[0]));
      chk("count_a", 32'(count_a), 32'(m_n[0]));
      chk("we_a",    32'(we_a),    32'(m_we[0]));
      if (m_we[0]) begin
         chk("addr_a", addr_a, m_addr[0]);
         chk("data_a", data_a, m_data[0]);
      end
      chk("ready_b", 32'(ready_b), 32'(m_load[1]));
      chk("done_b",  32'(done_b),  32'(m_done[1]));
      chk("count_b", 32'(count_b), 32'(m_n[1]));
      chk("we_b",    32'(we_b),    32'(m_we[1]));
      if (m_we[1]) begin
         chk("addr_b", addr_b, m_addr[1]);
         chk("data_b", data_b, m_data[1]);
      end
`ifdef INSTR_ENC_CHECKSUM_EN
      chk("cks_a", cks_a, m_csum[0]);
      chk("cks_b", cks_b, m_csum[1]);
`endif
      if (we_a) wr_a++;
      if (we_b) wr_b++;
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
   endtask

   task automatic rand_fields(input logic [2:0] cls);
      in_class = cls;
      rs       = 5'($urandom);
      rt       = 5'($urandom);
      rd       = 5'($urandom);
      shamt    = 5'($urandom);
      funct    = 6'($urandom);
      imm      = 16'($urandom);
      target   = 26'($urandom);
   endtask

   int wr0;

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      rand_fields(3'd0);
      @(negedge clk);
      step();
      step();
      rst = 1'b0;
      chk("rst_addr_a", addr_a, 32'h0000_0000);
      chk("rst_data_a", data_a, 32'h0000_0000);
      chk("rst_addr_b", addr_b, BASE_B);
      step();

      // Single R-type word ending the session
      start = 1'b1; step(); start = 1'b0;
      in_class = 3'd0; rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0; funct = 6'h20;
      in_valid = 1'b1; in_last = 1'b1;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      chk("r_we",    32'(we_a), 32'd1);
      chk("r_addr",  addr_a, 32'h0000_0000);
      chk("r_word",  data_a, 32'h0022_1820);
      chk("r_done",  32'(done_a), 32'd1);
      chk("r_count", 32'(count_a), 32'd1);
      step();
      chk("r_strobe_single", 32'(we_a), 32'd0);

      // Eight back-to-back accepts, one per class
      start = 1'b1; step(); start = 1'b0;
      wr0 = wr_a;
      for (int i = 0; i < 8; i++) begin
         rand_fields(3'(i));
         if (i == 2) begin rs = 5'd0; rt = 5'd8; imm = 16'd5; end
         if (i == 7) begin target = 26'h10; in_last = 1'b1; end
         in_valid = 1'b1;
         step();
         if (i == 2) chk("addi_word", data_a, 32'h2008_0005);
         if (i == 7) begin
            chk("jal_word", data_a, 32'h0C00_0010);
            chk("jal_addr", addr_a, 32'h0000_001C);
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      step();
      chk("b2b_writes", 32'(wr_a - wr0), 32'd8);

      // Depth limit on the shallow instance with valid held high
      start = 1'b1; step(); start = 1'b0;
      wr0 = wr_b;
      in_valid = 1'b1; in_last = 1'b0;
      for (int i = 0; i < 6; i++) begin
         rand_fields(3'($urandom));
         step();
         if (i == 3) begin
            chk("depth_ready", 32'(ready_b), 32'd0);
            chk("depth_done",  32'(done_b),  32'd1);
            chk("depth_count", 32'(count_b), 32'd4);
         end
      end
      chk("depth_writes", 32'(wr_b - wr0), 32'd4);
      // start while the deep instance is still loading is ignored
      in_valid = 1'b0; start = 1'b1; step(); start = 1'b0;
      chk("start_in_load", 32'(count_a), 32'd6);
      rand_fields(3'd6); in_valid = 1'b1; in_last = 1'b1; step();
      in_valid = 1'b0; in_last = 1'b0; step();

      // Toggled valid: writes only after accepted cycles
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 12; i++) begin
         rand_fields(3'($urandom));
         in_valid = (i % 2 == 0);
         in_last  = (i == 10);
         step();
      end
      in_valid = 1'b0; in_last = 1'b0; step();

      // Reset mid-session, with an accept pending on the reset edge
      start = 1'b1; step(); start = 1'b0;
      in_valid = 1'b1;
      rand_fields(3'd2); step();
      rand_fields(3'd4); step();
      rand_fields(3'd5); rst = 1'b1; step(); rst = 1'b0; in_valid = 1'b0;
      chk("rst_mid_we",    32'(we_a), 32'd0);
      chk("rst_mid_count", 32'(count_a), 32'd0);
      chk("rst_mid_ready", 32'(ready_a), 32'd0);
      start = 1'b1; step(); start = 1'b0;
      rand_fields(3'd1); in_valid = 1'b1; in_last = 1'b1; step();
      chk("restart_addr", addr_a, 32'h0000_0000);
      in_valid = 1'b0; in_last = 1'b0; step();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         rst      = ($urandom_range(0, 149) == 0);
         start    = ($urandom_range(0, 7) == 0);
         in_valid = ($urandom_range(0, 2) != 0);
         in_last  = ($urandom_range(0, 9) == 0);
         rand_fields(3'($urandom));
         step();
      end
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
